tff_counter_bank: RTL and testbench
===================================

Name: tff_counter_bank

Overview:
- Parametrised successor to the single-bit toggle flop: WIDTH toggle flops sharing one clock, reset and load path.
- Run-time mode select:
  - independent per-bit toggle
  - binary up count (T-chain)
  - binary down count
  - Gray-code up count
- Registered terminal-count pulse for cascading or timer use.
- Sits in the basic sequential-cell library; used by timers, prescalers and Gray pointers.

Parameters:
- WIDTH, 8, number of toggle bits in the bank (legal range 2..32).
- RESET_VAL, 0, value loaded into q on reset (WIDTH bits, truncated).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  advance enable; no state change when 0 (load excepted).
- mode  input  2  00 toggle, 01 binary up, 10 binary down, 11 Gray up.
- t  input  WIDTH  per-bit toggle enables, used only in mode 00.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value written on load.
- q  output  WIDTH  registered bank state.
- tc  output  1  registered terminal-count/wrap pulse.

Behaviour:
- Reset (async assert on rst high, released synchronously by design):
  - q = RESET_VAL, tc = 0.
  - Reset mid-count aborts immediately; no tc is generated.
- Per rising clk edge, priority load > en:
  - load=1: q <= load_val; tc <= 0. Applies regardless of en and mode.
  - en=0 and load=0: q holds; tc <= 0.
  - en=1, mode 00: q <= q ^ t; tc <= 0. t = 0 leaves q unchanged.
  - en=1, mode 01: q <= q + 1 modulo 2^WIDTH. Equivalent to bit i toggling when all lower bits are 1. tc <= 1 only when q was all-ones (wrap to 0).
  - en=1, mode 10: q <= q - 1 modulo 2^WIDTH. tc <= 1 only when q was 0 (wrap to all-ones).
  - en=1, mode 11: q is interpreted as Gray code. q <= bin2gray(gray2bin(q) + 1). Exactly one bit changes per step. tc <= 1 only when gray2bin(q) was all-ones, i.e. q = 1 followed by WIDTH-1 zeros, wrapping to 0.
- tc:
  - High for exactly one cycle, in the cycle after the wrapping edge, aligned with the new q.
  - Never asserted in mode 00.
- Latency: q reflects a command one cycle after the sampling edge; no combinational path from inputs to outputs.
- Mode changes take effect on the next enabled edge with no flush. q is reinterpreted as-is:
  - Switching 01 -> 11 treats the current binary value as a Gray value.
  - This is legal and deterministic.
- Arithmetic is WIDTH bits; no carry-out other than tc.

Optional Feature:
- Macro: TFF_STICKY_WRAP_EN.
- When defined:
  - Adds input clr_wrap (1 bit) and output wrap_flag (1 bit).
  - wrap_flag is set on any cycle tc is set and stays high until clr_wrap=1 is sampled.
  - Set wins over clear in the same cycle.
  - Reset value is 0.
- When undefined: neither port exists, and the core behaviour is unchanged.

Test Plan:
- Reset and toggle: WIDTH=8, RESET_VAL=8'hA5; assert rst mid-cycle -> q=A5 immediately. Release, mode 00, t=8'h0F, en=1 for 2 cycles -> q=AA then A5; tc stays 0.
- Up wrap: load 8'hFE, mode 01, en=1 for 3 cycles -> q=FF, 00, 01. tc=1 only in the cycle q=00.
- Down wrap with gating: load 8'h01, mode 10. en=1,1,0,1 -> q=00, FF, FF, FE. tc=1 only when q first becomes FF.
- Gray sequence: WIDTH=4, load 0, mode 11, 16 enabled cycles -> q=1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. Each step has Hamming distance 1; tc=1 only on 8 -> 0.
- Priority and async reset: load=1, en=1, mode 01, load_val=8'h3C -> q=3C (no increment). During counting, pulse rst between edges -> q=RESET_VAL at once, tc=0.
- Sticky flag (TFF_STICKY_WRAP_EN): up wrap sets wrap_flag=1 and it holds for 5 cycles. clr_wrap=1 in the same cycle as another tc -> wrap_flag stays 1. A later clr_wrap alone -> 0.

Source files
------------

// File: rtl/tff_counter_bank.sv
// Bank of WIDTH toggle flops with per-bit toggle, binary up/down and Gray-up modes plus a registered wrap pulse.
// Optional sticky wrap flag (clr_wrap / wrap_flag) is built when TFF_STICKY_WRAP_EN is defined.
module tff_counter_bank #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TFF_STICKY_WRAP_EN
  input  logic             clr_wrap,
  output logic             wrap_flag,
`endif
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_GRAY   = 2'b11;

  localparam logic [WIDTH-1:0] RST_Q = RESET_VAL[WIDTH-1:0];

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  logic [WIDTH-1:0] w_gray_bin;
  logic [WIDTH-1:0] w_gray_inc;
  logic [WIDTH-1:0] w_gray_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;

  // Gray-to-binary: each binary bit is the parity of the Gray bits at and above it.
  always_comb begin
    w_gray_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_gray_bin[i] = ^(r_q >> i);
    end
  end

  assign w_gray_inc  = w_gray_bin + 1'b1;
  assign w_gray_next = w_gray_inc ^ (w_gray_inc >> 1);

  always_comb begin
    w_q_next  = r_q;
    w_tc_next = 1'b0;
    if (load) begin
      w_q_next = load_val;
    end else if (en) begin
      case (mode)
        MODE_TOGGLE: w_q_next = r_q ^ t;
        MODE_UP: begin
          w_q_next  = r_q + 1'b1;
          w_tc_next = &r_q;
        end
        MODE_DOWN: begin
          w_q_next  = r_q - 1'b1;
          w_tc_next = (r_q == '0);
        end
        MODE_GRAY: begin
          w_q_next  = w_gray_next;
          w_tc_next = &w_gray_bin;
        end
        default: w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= RST_Q;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_next;
      r_tc <= w_tc_next;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

`ifdef TFF_STICKY_WRAP_EN
  logic r_wrap_flag;

  // Set takes priority so a wrap coinciding with a clear is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_flag <= 1'b0;
    end else if (w_tc_next) begin
      r_wrap_flag <= 1'b1;
    end else if (clr_wrap) begin
      r_wrap_flag <= 1'b0;
    end
  end

  assign wrap_flag = r_wrap_flag;
`endif

endmodule

// File: tb/tb_tff_counter_bank.sv
// Self-checking bench for tff_counter_bank: an 8-bit instance (RESET_VAL A5) and a 4-bit instance for the Gray sequence.
module tb_tff_counter_bank;

  logic       clk;
  logic       rst;
  logic       en8, load8;
  logic [1:0] mode8;
  logic [7:0] t8, lv8;
  logic [7:0] q8;
  logic       tc8;
  logic       en4, load4;
  logic [1:0] mode4;
  logic [3:0] t4, lv4;
  logic [3:0] q4;
  logic       tc4;
  logic       clr_wrap8, clr_wrap4;
  logic       wrap8, wrap4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  logic [4:0] exp4_q[$];

  tff_counter_bank #(.WIDTH(8), .RESET_VAL(32'hA5)) dut8 (
    .clk(clk), .rst(rst),
`ifdef TFF_STICKY_WRAP_EN
    .clr_wrap(clr_wrap8), .wrap_flag(wrap8),
`endif
    .en(en8), .mode(mode8), .t(t8), .load(load8), .load_val(lv8),
    .q(q8), .tc(tc8)
  );

  tff_counter_bank #(.WIDTH(4), .RESET_VAL(32'h0)) dut4 (
    .clk(clk), .rst(rst),
`ifdef TFF_STICKY_WRAP_EN
    .clr_wrap(clr_wrap4), .wrap_flag(wrap4),
`endif
    .en(en4), .mode(mode4), .t(t4), .load(load4), .load_val(lv4),
    .q(q4), .tc(tc4)
  );

`ifndef TFF_STICKY_WRAP_EN
  assign wrap8 = 1'b0;
  assign wrap4 = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference next-state model for the 8-bit bank: {tc, q}.
  function automatic logic [8:0] model8(input logic [7:0] cq, input logic ld, input logic [7:0] lv,
                                        input logic e, input logic [1:0] m, input logic [7:0] tt);
    logic [7:0] b;
    logic [7:0] g;
    if (ld) return {1'b0, lv};
    if (!e) return {1'b0, cq};
    case (m)
      2'd0: return {1'b0, cq ^ tt};
      2'd1: return {(cq == 8'hFF), 8'(cq + 8'd1)};
      2'd2: return {(cq == 8'h00), 8'(cq - 8'd1)};
      default: begin
        b[7] = cq[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ cq[i];
        g = b + 8'd1;
        return {(b == 8'hFF), g ^ {1'b0, g[7:1]}};
      end
    endcase
  endfunction

  // driver tasks: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge
  task automatic drive8(input logic ld, input logic [7:0] lv, input logic e, input logic [1:0] m, input logic [7:0] tt);
    @(negedge clk);
    load8 = ld; lv8 = lv; en8 = e; mode8 = m; t8 = tt;
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic ld, input logic [3:0] lv, input logic e, input logic [1:0] m);
    @(negedge clk);
    load4 = ld; lv4 = lv; en4 = e; mode4 = m; t4 = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (q8 !== 8'hA5 || tc8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_value: got q=%h tc=%b expected q=a5 tc=0", q8, tc8);
    end
    n_checks++;
    if (q4 !== 4'h0 || tc4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_value4: got q=%h tc=%b expected q=0 tc=0", q4, tc4);
    end
  endtask

  task automatic test_toggle;
    logic [7:0] tv[4] = '{8'h0F, 8'h0F, 8'h00, 8'hFF};
    logic [8:0] ev[4] = '{{1'b0, 8'hAA}, {1'b0, 8'hA5}, {1'b0, 8'hA5}, {1'b0, 8'h5A}};
    logic [8:0] got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev[i]);
      drive8(1'b0, 8'h00, 1'b1, 2'd0, tv[i]);
      got = {tc8, q8};
      n_checks++;
      if (got !== exp_q.pop_front()) begin
        n_fail++;
        $display("FAIL toggle step %0d: got tc,q=%h expected %h", i, got, ev[i]);
      end
    end
    // all-ones to zero in toggle mode must not pulse tc
    exp_q.push_back({1'b0, 8'hFF});
    drive8(1'b1, 8'hFF, 1'b0, 2'd0, 8'h00);
    exp_q.push_back({1'b0, 8'h00});
    drive8(1'b0, 8'h00, 1'b1, 2'd0, 8'hFF);
    for (int i = 0; i < 1; i++) begin
      got = {tc8, q8};
      void'(exp_q.pop_front());
      n_checks++;
      if (got !== exp_q.pop_front()) begin
        n_fail++;
        $display("FAIL toggle_no_tc: got tc,q=%h expected 000", got);
      end
    end
  endtask

  task automatic test_up_wrap;
    logic [8:0] ev[4] = '{{1'b0, 8'hFE}, {1'b0, 8'hFF}, {1'b1, 8'h00}, {1'b0, 8'h01}};
    logic [8:0] got;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ev[i]);
      drive8(i == 0, 8'hFE, 1'b1, 2'd1, 8'h00);
      got = {tc8, q8};
      n_checks++;
      if (got !== exp_q.pop_front()) begin
        n_fail++;
        $display("FAIL up_wrap step %0d: got tc,q=%h expected %h", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_down_wrap;
    logic       ev_en[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [8:0] ev[5]    = '{{1'b0, 8'h01}, {1'b0, 8'h00}, {1'b1, 8'hFF}, {1'b0, 8'hFF}, {1'b0, 8'hFE}};
    logic [8:0] got;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ev[i]);
      drive8(i == 0, 8'h01, ev_en[i], 2'd2, 8'h00);
      got = {tc8, q8};
      n_checks++;
      if (got !== exp_q.pop_front()) begin
        n_fail++;
        $display("FAIL down_wrap step %0d: got tc,q=%h expected %h", i, got, ev[i]);
      end
    end
  endtask

  task automatic test_gray4;
    logic [3:0] gseq[16] = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    logic [3:0] prev;
    logic [4:0] got;
    logic [4:0] ev;
    drive4(1'b1, 4'h0, 1'b0, 2'd3);
    prev = q4;
    for (int i = 0; i < 16; i++) begin
      exp4_q.push_back({i == 15, gseq[i]});
      drive4(1'b0, 4'h0, 1'b1, 2'd3);
      got = {tc4, q4};
      ev  = exp4_q.pop_front();
      n_checks++;
      if (got !== ev) begin
        n_fail++;
        $display("FAIL gray4 step %0d: got tc,q=%h expected %h", i, got, ev);
      end
      n_checks++;
      if ($countones(prev ^ q4) != 1) begin
        n_fail++;
        $display("FAIL gray4_hamming step %0d: got %h -> %h expected one-bit change", i, prev, q4);
      end
      prev = q4;
    end
    drive4(1'b0, 4'h0, 1'b0, 2'd3);
  endtask

  task automatic test_priority_and_reset;
    logic [8:0] ev[5] = '{{1'b0, 8'h3C}, {1'b0, 8'h3D}, {1'b0, 8'h3E}, {1'b0, 8'hFF}, {1'b1, 8'h00}};
    logic       ld[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] lv[5] = '{8'h3C, 8'h00, 8'h00, 8'hFF, 8'h00};
    logic [8:0] got;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ev[i]);
      drive8(ld[i], lv[i], 1'b1, 2'd1, 8'h00);
      got = {tc8, q8};
      n_checks++;
      if (got !== exp_q.pop_front()) begin
        n_fail++;
        $display("FAIL priority step %0d: got tc,q=%h expected %h", i, got, ev[i]);
      end
    end
    // async reset pulse between edges while tc is high
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (q8 !== 8'hA5 || tc8 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got q=%h tc=%b expected q=a5 tc=0", q8, tc8);
    end
    n_checks++;
    if (wrap8 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_wrap: got %b expected 0", wrap8);
    end
    #1 rst = 1'b0;
    exp_q.push_back({1'b0, 8'hA5});
    drive8(1'b0, 8'h00, 1'b0, 2'd1, 8'h00);
    got = {tc8, q8};
    n_checks++;
    if (got !== exp_q.pop_front()) begin
      n_fail++;
      $display("FAIL post_reset_hold: got tc,q=%h expected 0a5", got);
    end
  endtask

  task automatic test_mode_switch;
    logic [8:0] got;
    logic [8:0] ev;
    // binary A5 reinterpreted as Gray: gray2bin = C6, +1 = C7, bin2gray = A4
    exp_q.push_back({1'b0, 8'hA4});
    drive8(1'b0, 8'h00, 1'b1, 2'd3, 8'h00);
    got = {tc8, q8};
    ev  = exp_q.pop_front();
    n_checks++;
    if (got !== ev) begin
      n_fail++;
      $display("FAIL mode_switch_gray: got tc,q=%h expected %h", got, ev);
    end
    exp_q.push_back({1'b0, 8'h80});
    drive8(1'b1, 8'h80, 1'b1, 2'd3, 8'h00);
    exp_q.push_back({1'b1, 8'h00});
    drive8(1'b0, 8'h00, 1'b1, 2'd3, 8'h00);
    got = {tc8, q8};
    void'(exp_q.pop_front());
    ev = exp_q.pop_front();
    n_checks++;
    if (got !== ev) begin
      n_fail++;
      $display("FAIL gray8_wrap: got tc,q=%h expected %h", got, ev);
    end
  endtask

  task automatic test_random;
    logic [7:0] mq;
    logic [8:0] nx;
    logic [8:0] got;
    logic [8:0] ev;
    logic       ld, e;
    logic [1:0] m;
    logic [7:0] lv, tt;
    mq = q8;
    for (int i = 0; i < 200; i++) begin
      ld = ($urandom_range(0, 9) == 0);
      e  = ($urandom_range(0, 4) != 0);
      m  = 2'($urandom_range(0, 3));
      lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 5));
      tt = 8'($urandom_range(0, 255));
      nx = model8(mq, ld, lv, e, m, tt);
      exp_q.push_back(nx);
      mq = nx[7:0];
      drive8(ld, lv, e, m, tt);
      got = {tc8, q8};
      ev  = exp_q.pop_front();
      n_checks++;
      if (got !== ev) begin
        n_fail++;
        $display("FAIL random step %0d: got tc,q=%h expected %h", i, got, ev);
      end
    end
  endtask

`ifdef TFF_STICKY_WRAP_EN
  task automatic test_sticky;
    logic exp_w;
    clr_wrap8 = 1'b1;
    drive8(1'b1, 8'hFF, 1'b0, 2'd1, 8'h00);
    clr_wrap8 = 1'b0;
    n_checks++;
    if (wrap8 !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear_init: got %b expected 0", wrap8);
    end
    drive8(1'b0, 8'h00, 1'b1, 2'd1, 8'h00);
    n_checks++;
    if (wrap8 !== 1'b1 || tc8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set: got wrap=%b tc=%b expected wrap=1 tc=1", wrap8, tc8);
    end
    for (int i = 0; i < 5; i++) begin
      drive8(1'b0, 8'h00, 1'b0, 2'd1, 8'h00);
      n_checks++;
      if (wrap8 !== 1'b1) begin
        n_fail++;
        $display("FAIL sticky_hold cycle %0d: got %b expected 1", i, wrap8);
      end
    end
    drive8(1'b1, 8'hFF, 1'b0, 2'd1, 8'h00);
    clr_wrap8 = 1'b1;
    drive8(1'b0, 8'h00, 1'b1, 2'd1, 8'h00);
    clr_wrap8 = 1'b0;
    n_checks++;
    if (wrap8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got %b expected 1", wrap8);
    end
    clr_wrap8 = 1'b1;
    drive8(1'b0, 8'h00, 1'b0, 2'd1, 8'h00);
    clr_wrap8 = 1'b0;
    exp_w = 1'b0;
    n_checks++;
    if (wrap8 !== exp_w) begin
      n_fail++;
      $display("FAIL sticky_clear: got %b expected %b", wrap8, exp_w);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    en8 = 1'b0; load8 = 1'b0; mode8 = 2'd0; t8 = 8'h00; lv8 = 8'h00;
    en4 = 1'b0; load4 = 1'b0; mode4 = 2'd0; t4 = 4'h0; lv4 = 4'h0;
    clr_wrap8 = 1'b0; clr_wrap4 = 1'b0;
    test_reset();
    test_toggle();
    test_up_wrap();
    test_down_wrap();
    test_gray4();
    test_priority_and_reset();
    test_mode_switch();
    test_random();
`ifdef TFF_STICKY_WRAP_EN
    test_sticky();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
